// File: rtl/wb_uart_host_pkg.sv
// wb_uart_host_pkg
// Shared definitions for the Wishbone UART host: register byte offsets,
// STATUS bit indices, TX/RX FSM state encodings, the minimum baud divisor
// and a divisor clamp helper.
package wb_uart_host_pkg;

  // Register byte offsets within the 16-byte window
  localparam logic [3:0] REG_TXDATA = 4'h0;
  localparam logic [3:0] REG_RXDATA = 4'h4;
  localparam logic [3:0] REG_STATUS = 4'h8;
  localparam logic [3:0] REG_DIV    = 4'hC;

  // STATUS bit positions
  localparam int unsigned ST_TX_BUSY    = 0;
  localparam int unsigned ST_RX_VALID   = 1;
  localparam int unsigned ST_RX_OVERRUN = 2;
  localparam int unsigned ST_FRAME_ERR  = 3;
  localparam int unsigned ST_TX_DROP    = 4;
  localparam int unsigned STATUS_W      = 5;

  // Smallest usable divisor; keeps the RX half-bit wait non-zero
  localparam logic [15:0] DIV_MIN = 16'd4;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  function automatic logic [15:0] clamp_div(input logic [15:0] d);
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core
// 8N1 receiver: 2-flop synchronizer, start-bit validation at mid-bit,
// eight LSB-first data samples and a stop-bit check.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   rx           asynchronous serial input
//   div          clock cycles per bit (latched at each start edge)
//   byte_valid   1-cycle pulse, byte_data holds a good byte
//   byte_data    last correctly framed byte
//   frame_err    1-cycle pulse when the stop bit samples low
module uart_rx_core
  import wb_uart_host_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  input  logic [15:0] div,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        frame_err
);

  logic        sync1;
  logic        rx_s;
  logic        rx_prev;
  rx_state_e   state;
  logic [15:0] cnt;
  logic [15:0] div_q;
  logic [15:0] half_m1;
  logic [15:0] full_m1;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;

  assign half_m1 = {1'b0, div_q[15:1]} - 16'd1;
  assign full_m1 = div_q - 16'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1      <= 1'b1;
      rx_s       <= 1'b1;
      rx_prev    <= 1'b1;
      state      <= RX_IDLE;
      cnt        <= '0;
      div_q      <= DIV_MIN;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      frame_err  <= 1'b0;
    end else begin
      sync1      <= rx;
      rx_s       <= sync1;
      rx_prev    <= rx_s;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (rx_prev && !rx_s) begin
            state <= RX_START;
            cnt   <= '0;
            div_q <= div;
          end
        end
        RX_START: begin
          if (cnt == half_m1) begin
            cnt <= '0;
            // Line back high at mid start bit: a glitch, not a frame
            if (rx_s) begin
              state <= RX_IDLE;
            end else begin
              state   <= RX_DATA;
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RX_DATA: begin
          if (cnt == full_m1) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[7:1]};
            if (bit_idx == 3'd7) begin
              state <= RX_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RX_STOP: begin
          if (cnt == full_m1) begin
            cnt   <= '0;
            state <= RX_IDLE;
            if (rx_s) begin
              byte_valid <= 1'b1;
              byte_data  <= shreg;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/wb_uart_host.sv
// wb_uart_host
// Wishbone-slave UART peer for an on-chip core: 8N1 transmit and receive,
// one-byte holding registers, sticky error flags, programmable divisor.
// Ports:
//   wb_clk_i, wb_rst_ni        clock, synchronous active-low reset
//   wbs_stb_i/cyc_i/we_i       Wishbone classic strobe, cycle, write enable
//   wbs_sel_i, wbs_adr_i       byte lanes, address
//   wbs_dat_i, wbs_dat_o       write / read data
//   wbs_ack_o                  1-cycle acknowledge
//   uart_tx                    serial out (idle high)
//   uart_rx                    asynchronous serial in
//   irq                        mirrors rx_valid
module wb_uart_host
  import wb_uart_host_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [15:0] CLK_DIV   = 16'd434
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        uart_tx,
  input  logic        uart_rx,
  output logic        irq
);

  logic                addr_hit;
  logic                served;
  logic                req;
  logic                wr;
  logic                rd;
  logic [3:0]          reg_off;
  logic [31:0]         rdata;
  logic [15:0]         div_wr;
  logic [STATUS_W-1:0] status;

  logic [15:0] div;
  logic        rx_valid;
  logic        rx_overrun;
  logic        frame_err_flag;
  logic        tx_drop;
  logic [7:0]  rx_byte;

  tx_state_e   tx_state;
  logic [15:0] tx_cnt;
  logic [15:0] tx_div;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;
  logic        tx_busy;
  logic        tx_wr;
  logic        tx_start;

  logic        rx_byte_valid;
  logic [7:0]  rx_new_byte;
  logic        rx_frame_err;

  logic        unused_inputs;
  assign unused_inputs = ^{wbs_adr_i[1:0], wbs_dat_i[31:16], wbs_sel_i[3:2]};

  // One ack per strobe assertion: 'served' stays set until stb/cyc drop,
  // so a held strobe is acknowledged only once.
  assign addr_hit = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign req      = wbs_stb_i && wbs_cyc_i && addr_hit && !served;
  assign wr       = req && wbs_we_i;
  assign rd       = req && !wbs_we_i;
  assign reg_off  = {wbs_adr_i[3:2], 2'b00};

  assign tx_busy  = (tx_state != TX_IDLE);
  assign tx_wr    = wr && (reg_off == REG_TXDATA) && wbs_sel_i[0];
  assign tx_start = tx_wr && !tx_busy;
  assign irq      = rx_valid;

  always_comb begin
    status                = '0;
    status[ST_TX_BUSY]    = tx_busy;
    status[ST_RX_VALID]   = rx_valid;
    status[ST_RX_OVERRUN] = rx_overrun;
    status[ST_FRAME_ERR]  = frame_err_flag;
    status[ST_TX_DROP]    = tx_drop;
  end

  always_comb begin
    rdata = '0;
    case (reg_off)
      REG_RXDATA: rdata = {24'h0, rx_byte};
      REG_STATUS: rdata = {{(32-STATUS_W){1'b0}}, status};
      REG_DIV:    rdata = {16'h0, div};
      default:    rdata = '0;
    endcase
  end

  always_comb begin
    div_wr = div;
    if (wbs_sel_i[0]) div_wr[7:0]  = wbs_dat_i[7:0];
    if (wbs_sel_i[1]) div_wr[15:8] = wbs_dat_i[15:8];
  end

  uart_rx_core u_rx (
    .clk        (wb_clk_i),
    .rst_n      (wb_rst_ni),
    .rx         (uart_rx),
    .div        (div),
    .byte_valid (rx_byte_valid),
    .byte_data  (rx_new_byte),
    .frame_err  (rx_frame_err)
  );

  // Bus interface and register file
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      wbs_ack_o      <= 1'b0;
      wbs_dat_o      <= '0;
      served         <= 1'b0;
      div            <= CLK_DIV;
      rx_valid       <= 1'b0;
      rx_overrun     <= 1'b0;
      frame_err_flag <= 1'b0;
      tx_drop        <= 1'b0;
      rx_byte        <= '0;
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= rd ? rdata : '0;

      if (!(wbs_stb_i && wbs_cyc_i)) begin
        served <= 1'b0;
      end else if (req) begin
        served <= 1'b1;
      end

      if (wr && (reg_off == REG_DIV)) begin
        div <= clamp_div(div_wr);
      end

      // W1C clears come first so a same-cycle event still sets the flag
      if (wr && (reg_off == REG_STATUS) && wbs_sel_i[0]) begin
        if (wbs_dat_i[ST_RX_OVERRUN]) rx_overrun     <= 1'b0;
        if (wbs_dat_i[ST_FRAME_ERR])  frame_err_flag <= 1'b0;
        if (wbs_dat_i[ST_TX_DROP])    tx_drop        <= 1'b0;
      end

      // A byte landing in the same cycle as an RXDATA read replaces the
      // consumed one rather than counting as an overrun.
      if (rx_byte_valid) begin
        if (rx_valid && !(rd && (reg_off == REG_RXDATA))) begin
          rx_overrun <= 1'b1;
        end else begin
          rx_byte  <= rx_new_byte;
          rx_valid <= 1'b1;
        end
      end else if (rd && (reg_off == REG_RXDATA)) begin
        rx_valid <= 1'b0;
      end

      if (rx_frame_err) frame_err_flag <= 1'b1;
      if (tx_wr && tx_busy) tx_drop <= 1'b1;
    end
  end

  // Transmitter FSM
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      tx_state <= TX_IDLE;
      uart_tx  <= 1'b1;
      tx_cnt   <= '0;
      tx_div   <= DIV_MIN;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          uart_tx <= 1'b1;
          if (tx_start) begin
            tx_state <= TX_START;
            uart_tx  <= 1'b0;
            tx_cnt   <= '0;
            tx_div   <= div;
            tx_shift <= wbs_dat_i[7:0];
          end
        end
        TX_START: begin
          if (tx_cnt == tx_div - 16'd1) begin
            tx_cnt   <= '0;
            tx_state <= TX_DATA;
            tx_bit   <= '0;
            uart_tx  <= tx_shift[0];
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == tx_div - 16'd1) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              tx_state <= TX_STOP;
              uart_tx  <= 1'b1;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              uart_tx  <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        TX_STOP: begin
          if (tx_cnt == tx_div - 16'd1) begin
            tx_cnt   <= '0;
            tx_state <= TX_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        default: begin
          tx_state <= TX_IDLE;
          uart_tx  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_uart_host.sv
`timescale 1ns/1ps
module tb_wb_uart_host;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] A_TX = BASE + 32'h0;
  localparam logic [31:0] A_RX = BASE + 32'h4;
  localparam logic [31:0] A_ST = BASE + 32'h8;
  localparam logic [31:0] A_DV = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat, rdat;
  logic        ack;
  logic        uart_tx, uart_rx, irq;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  wb_uart_host #(.BASE_ADDR(BASE), .CLK_DIV(16'd434)) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .wbs_stb_i (stb),
    .wbs_cyc_i (cyc),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_ack_o (ack),
    .wbs_dat_o (rdat),
    .uart_tx   (uart_tx),
    .uart_rx   (uart_rx),
    .irq       (irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic w, output logic [31:0] q, output int lat);
    @(posedge clk); #1;
    adr = a; wdat = d; sel = s; we = w; stb = 1'b1; cyc = 1'b1;
    lat = 0;
    q   = '0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        lat = i;
        q   = rdat;
        break;
      end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    if (lat == 0) check("ack_timeout", 32'(ack), 32'd1);
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] q;
    int lat;
    xfer(a, d, 4'hF, 1'b1, q, lat);
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] q);
    int lat;
    xfer(a, '0, 4'hF, 1'b0, q, lat);
  endtask

  // Serial frame into the DUT at 8 clocks per bit
  task automatic send_rx(input logic [7:0] b, input logic stop);
    @(posedge clk); #1;
    uart_rx = 1'b0;
    tick(8);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(8);
    end
    uart_rx = stop;
    tick(8);
    uart_rx = 1'b1;
    tick(4);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] q;
    logic [9:0]  frame;
    int          lat;
    int          n;
    logic        done;

    stb = 0; cyc = 0; we = 0; sel = 0; adr = A_ST; wdat = 0; uart_rx = 1; rst_n = 0;

    // Reset with bus and line activity
    stb = 1; cyc = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      uart_rx = ~uart_rx;
    end
    check("rst_uart_tx", 32'(uart_tx), 32'd1);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_dat_o", rdat, 32'd0);
    stb = 0; cyc = 0; uart_rx = 1;
    @(posedge clk); #1;
    rst_n = 1;
    tick(4);
    wb_read(A_ST, q); check("rst_status", q, 32'h0);
    wb_read(A_DV, q); check("rst_div", q, 32'd434);

    // DIV clamping and byte-lane gating
    wb_write(A_DV, 32'd2);
    wb_read(A_DV, q); check("div_clamp", q, 32'd4);
    xfer(A_DV, 32'h0000_1200, 4'b0010, 1'b1, q, lat);
    wb_read(A_DV, q); check("div_sel_hi", q, 32'h1204);
    wb_write(A_DV, 32'd8);
    wb_read(A_DV, q); check("div_set8", q, 32'd8);
    wb_read(A_TX, q); check("txdata_read_zero", q, 32'h0);

    // TX 0x55: start, LSB-first data, stop, checked mid-bit
    xfer(A_TX, 32'h55, 4'hF, 1'b1, q, lat);
    check("tx_ack_lat", 32'(lat), 32'd1);
    frame = {1'b1, 8'h55, 1'b0};
    tick(4);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("tx_bit%0d", i), 32'(uart_tx), 32'(frame[i]));
      tick(8);
    end
    wb_read(A_ST, q); check("tx_busy_after", q, 32'h0);

    // Second frame, then a write while busy is dropped
    wb_write(A_TX, 32'hF0);
    wb_read(A_ST, q); check("tx_busy_during", q, 32'h1);
    wb_write(A_TX, 32'h0F);
    wb_read(A_ST, q); check("tx_drop_set", q, 32'h11);
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      wb_read(A_ST, q);
      if (q[0] == 1'b0) done = 1'b1;
    end
    check("tx_idle_wait", 32'(done), 32'd1);
    n = 0;
    for (int i = 0; i < 120; i++) begin
      tick(1);
      if (uart_tx == 1'b0) n++;
    end
    check("tx_no_extra_frame", 32'(n), 32'd0);
    wb_write(A_ST, 32'h10);
    wb_read(A_ST, q); check("tx_drop_clear", q, 32'h0);

    // RX 0xA3
    send_rx(8'hA3, 1'b1);
    check("rx_irq_set", 32'(irq), 32'd1);
    wb_read(A_RX, q); check("rx_data_a3", q, 32'h0000_00A3);
    check("rx_irq_clear", 32'(irq), 32'd0);

    // Overrun keeps the first byte
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    wb_read(A_ST, q); check("ovr_status", q, 32'h6);
    wb_read(A_RX, q); check("ovr_data", q, 32'h11);
    wb_write(A_ST, 32'h4);
    wb_read(A_ST, q); check("ovr_clear", q, 32'h0);

    // Stop bit low
    send_rx(8'h5A, 1'b0);
    wb_read(A_ST, q); check("ferr_status", q, 32'h8);
    check("ferr_irq", 32'(irq), 32'd0);
    wb_write(A_ST, 32'h8);
    wb_read(A_ST, q); check("ferr_clear", q, 32'h0);

    // 3-cycle glitch, then a good byte proves the receiver recovered
    @(posedge clk); #1;
    uart_rx = 1'b0;
    tick(3);
    uart_rx = 1'b1;
    tick(100);
    wb_read(A_ST, q); check("glitch_status", q, 32'h0);
    check("glitch_irq", 32'(irq), 32'd0);
    send_rx(8'h3C, 1'b1);
    wb_read(A_RX, q); check("post_glitch_data", q, 32'h3C);

    // Held strobe: one ack only
    @(posedge clk); #1;
    adr = A_ST; we = 0; sel = 4'hF; stb = 1; cyc = 1;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (ack) n++;
    end
    stb = 0; cyc = 0;
    @(posedge clk); #1;
    if (ack) n++;
    check("held_stb_acks", 32'(n), 32'd1);

    // Outside decode range
    @(posedge clk); #1;
    adr = BASE + 32'h10; stb = 1; cyc = 1;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (ack) n++;
    end
    stb = 0; cyc = 0;
    check("out_of_range_ack", 32'(n), 32'd0);

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
